// File: rtl/heartbeat_monitor.sv
// heartbeat_monitor: receive-side checker for an asynchronous heartbeat pad signal.
// Synchronises sig_in, measures rise-to-rise intervals in clk cycles, checks each
// against [MIN_PERIOD, MAX_PERIOD] and tracks lock/loss with a saturating error count.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   sig_in         raw pad input (asynchronous to clk)
//   clr_err        synchronous clear of err_count
//   state          0 IDLE, 1 ACQUIRE, 2 LOCKED, 3 LOST
//   locked         state == LOCKED
//   period         last checked interval
//   period_valid   one-cycle pulse when period updates
//   timeout        one-cycle pulse on loss of heartbeat
//   err_count      saturating count of bad periods plus timeouts
module heartbeat_monitor #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MIN_PERIOD = 8,
  parameter int unsigned MAX_PERIOD = 16,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             clr_err,
  output logic [1:0]       state,
  output logic             locked,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam int unsigned      GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_PERIOD);
  localparam logic [GOOD_W-1:0] LOCK_C = GOOD_W'(LOCK_COUNT);

  state_t              state_q, state_d;
  logic                s1_q, s2_q, s3_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [CNT_W-1:0]    period_d;
  logic                pv_d, tmo_d, locked_d, err_ev;
  logic [ERR_W-1:0]    err_d;
  logic                rise, in_window;
  logic [GOOD_W-1:0]   good_inc;

  assign rise      = s2_q & ~s3_q;
  assign in_window = (cnt_q >= MIN_C) && (cnt_q <= MAX_C);
  assign good_inc  = good_q + GOOD_W'(1);
  assign state     = 2'(state_q);

  // Three-flop synchroniser; s3 only serves edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Interval counter: restarts at 1 on a rise so its value at the next rise is the period.
  always_comb begin
    cnt_d = cnt_q;
    if (rise)                  cnt_d = CNT_W'(1);
    else if (cnt_q != '1)      cnt_d = cnt_q + CNT_W'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    period_d = period;
    pv_d     = 1'b0;
    tmo_d    = 1'b0;
    err_ev   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (rise) begin
          pv_d     = 1'b1;
          period_d = cnt_q;
          if (in_window) begin
            good_d = good_inc;
            if (good_inc == LOCK_C) state_d = LOCKED;
          end else begin
            good_d = '0;
            err_ev = 1'b1;
          end
        end else if (cnt_q == MAX_C) begin
          state_d = LOST;
          tmo_d   = 1'b1;
          err_ev  = 1'b1;
        end
      end
      LOCKED: begin
        if (rise) begin
          pv_d     = 1'b1;
          period_d = cnt_q;
          if (!in_window) begin
            state_d = ACQUIRE;
            good_d  = '0;
            err_ev  = 1'b1;
          end
        end else if (cnt_q == MAX_C) begin
          state_d = LOST;
          tmo_d   = 1'b1;
          err_ev  = 1'b1;
        end
      end
      LOST: begin
        // First edge after loss only re-arms; its interval is meaningless.
        if (rise) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    locked_d = (state_d == LOCKED);
  end

  // Error counter: a clear coinciding with an error leaves exactly that error counted.
  always_comb begin
    err_d = err_count;
    if (clr_err)                          err_d = err_ev ? ERR_W'(1) : '0;
    else if (err_ev && (err_count != '1)) err_d = err_count + ERR_W'(1);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      good_q       <= '0;
      locked       <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      err_count    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      good_q       <= good_d;
      locked       <= locked_d;
      period       <= period_d;
      period_valid <= pv_d;
      timeout      <= tmo_d;
      err_count    <= err_d;
    end
  end

endmodule

// File: tb/tb_heartbeat_monitor.sv
`timescale 1ns/1ps
// tb_heartbeat_monitor: directed bench for heartbeat_monitor with a period scoreboard.
module tb_heartbeat_monitor;

  logic        clk;
  logic        rst_n;
  logic        sig_in;
  logic        clr_err;
  logic [1:0]  state;
  logic        locked;
  logic [15:0] period;
  logic        period_valid;
  logic        timeout;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int tmo_cnt  = 0;
  int exp_q[$];

  heartbeat_monitor #(
    .CNT_W(16), .MIN_PERIOD(8), .MAX_PERIOD(16), .LOCK_COUNT(4), .ERR_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .clr_err(clr_err),
    .state(state), .locked(locked), .period(period), .period_valid(period_valid),
    .timeout(timeout), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard sink: every period_valid must match the next queued interval.
  always @(negedge clk) begin
    if (timeout) tmo_cnt++;
    if (period_valid) begin
      chk("pv_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("period", 32'(period), exp_q.pop_front());
    end
  end

  // Square wave driven at negedges; first_exp < 0 means the first rise is not checked.
  task automatic wave(input int p, input int n, input int first_exp);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      if (i > 0) exp_q.push_back(p);
      else if (first_exp >= 0) exp_q.push_back(first_exp);
      repeat (p / 2) @(negedge clk);
      sig_in = 1'b0;
      repeat (p - p / 2) @(negedge clk);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"},  32'(state), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_period"}, 32'(period), 0);
    chk({tag, "_pv"},     32'(period_valid), 0);
    chk({tag, "_tmo"},    32'(timeout), 0);
    chk({tag, "_err"},    32'(err_count), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int     t0;
    longint t_next, idx, idx_prev;
    rst_n   = 1'b0;
    sig_in  = 1'b0;
    clr_err = 1'b0;
    idx_prev = 0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Lock on a 12-cycle wave.
    wave(12, 1, -1);
    chk("t1_acquire", 32'(state), 1);
    wave(12, 3, 12);
    chk("t1_three_good", 32'(state), 1);
    wave(12, 1, 12);
    chk("t1_locked_state", 32'(state), 2);
    chk("t1_locked", 32'(locked), 1);
    chk("t1_err", 32'(err_count), 0);

    // Window edges: 8 and 16 good, 7 bad, 17 times out.
    wave(8, 2, 12);
    wave(16, 2, 8);
    chk("t2_edges_locked", 32'(state), 2);
    wave(7, 1, 16);
    wave(12, 1, 7);
    chk("t2_short_state", 32'(state), 1);
    chk("t2_short_err", 32'(err_count), 1);
    chk("t2_short_period", 32'(period), 7);
    t0 = tmo_cnt;
    wave(17, 1, 12);
    repeat (3) @(negedge clk);
    chk("t2_long_tmo", 32'(tmo_cnt - t0), 1);
    chk("t2_long_state", 32'(state), 3);
    chk("t2_long_err", 32'(err_count), 2);
    chk("t2_long_period", 32'(period), 12);

    // Loss and recovery with exact timeout latency.
    wave(10, 5, -1);
    chk("t3_locked", 32'(state), 2);
    t0 = tmo_cnt;
    sig_in = 1'b1;
    exp_q.push_back(10);
    repeat (5) @(negedge clk);
    sig_in = 1'b0;
    repeat (13) @(negedge clk);
    chk("t3_no_early_tmo", 32'(timeout), 0);
    chk("t3_pre_state", 32'(state), 2);
    @(negedge clk);
    chk("t3_tmo_pulse", 32'(timeout), 1);
    chk("t3_lost", 32'(state), 3);
    chk("t3_err", 32'(err_count), 3);
    repeat (40) @(negedge clk);
    chk("t3_single_tmo", 32'(tmo_cnt - t0), 1);
    chk("t3_still_lost", 32'(state), 3);
    wave(10, 1, -1);
    chk("t3_reacquire", 32'(state), 1);
    wave(10, 4, 10);
    chk("t3_relocked", 32'(state), 2);

    // Error counter saturation and clears.
    wave(5, 261, 10);
    chk("t4_sat_err", 32'(err_count), 255);
    chk("t4_sat_state", 32'(state), 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t4_clr", 32'(err_count), 0);
    repeat (20) @(negedge clk);
    chk("t4_tmo_state", 32'(state), 3);
    chk("t4_tmo_err", 32'(err_count), 1);
    wave(5, 1, -1);
    sig_in = 1'b1;
    exp_q.push_back(5);
    repeat (2) @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    sig_in  = 1'b0;
    chk("t4_clr_coincident", 32'(err_count), 1);
    chk("t4_clr_state", 32'(state), 1);
    repeat (25) @(negedge clk);
    chk("t4_end_err", 32'(err_count), 2);
    wave(12, 5, -1);
    chk("t5_pre_locked", 32'(locked), 1);

    // Asynchronous reset mid-LOCKED, release with sig_in high.
    sig_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("t5_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_idle_2clk", 32'(state), 0);
    @(negedge clk);
    chk("t5_acquire_3clk", 32'(state), 1);

    // Random-phase wave around 12 clocks; expected intervals from sampling-edge model.
    sig_in = 1'b0;
    repeat (25) @(negedge clk);
    chk("t6_lost", 32'(state), 3);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t6_clr", 32'(err_count), 0);
    t_next = longint'($time) + 3;
    for (int i = 0; i < 21; i++) begin
      if (i > 0) t_next = t_next + 115 + longint'($urandom_range(0, 10));
      if (t_next % 10 == 5) t_next = t_next + 1;
      #(t_next - longint'($time));
      sig_in = 1'b1;
      idx = (t_next + 5) / 10;
      if (i > 0) exp_q.push_back(int'(idx - idx_prev));
      idx_prev = idx;
      #50;
      sig_in = 1'b0;
    end
    repeat (6) @(negedge clk);
    chk("t6_locked_state", 32'(state), 2);
    chk("t6_locked", 32'(locked), 1);
    chk("t6_err", 32'(err_count), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
